// File: rtl/fifo_stream_reader.sv
// Pops words from a registered-read source FIFO into a 2-entry skid buffer and presents them
// as a valid/ready stream; supports idle, continuous streaming and a self-terminating drain.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_read_data,
  output logic                  o_fifo_read_en,
  input  logic                  i_enable,
  input  logic                  i_drain_req,
  output logic                  o_out_valid,
  output logic [DATA_WIDTH-1:0] o_out_data,
  input  logic                  i_out_ready,
  output logic                  o_drain_done,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_pop_count
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStream = 2'd1;
  localparam logic [1:0] StDrain  = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [1:0]            r_occ;
  logic [1:0]            w_occ_next;
  logic                  r_inflight;
  logic                  r_drain_done;
  logic                  w_drain_exit;
  logic [CNT_WIDTH-1:0]  r_pop_count;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [DATA_WIDTH-1:0] w_buf0_next;
  logic [DATA_WIDTH-1:0] w_buf1_next;
  logic [1:0]            w_pending;
  logic                  w_pop_allowed;
  logic                  w_read_en;
  logic                  w_xfer;
  logic                  w_cap;

  // Pending counts the buffered words plus the one arriving this cycle. It deliberately ignores
  // any dequeue happening now so that o_fifo_read_en never depends on i_out_ready.
  assign w_pending     = r_occ + {1'b0, r_inflight};
  assign w_pop_allowed = (r_state == StStream) || (r_state == StDrain);
  assign w_read_en     = w_pop_allowed && !i_fifo_empty && (w_pending < 2'd2) && !i_rst;
  assign w_xfer        = (r_occ != 2'd0) && i_out_ready;
  assign w_cap         = r_inflight;

  assign o_fifo_read_en = w_read_en;
  assign o_out_valid    = (r_occ != 2'd0);
  assign o_out_data     = r_buf0;
  assign o_drain_done   = r_drain_done;
  assign o_pop_count    = r_pop_count;
  assign o_busy         = (r_state != StIdle) || (r_occ != 2'd0) || r_inflight;

  always_comb begin
    w_state_next = r_state;
    w_drain_exit = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_drain_req) begin
          w_state_next = StDrain;
        end else if (i_enable) begin
          w_state_next = StStream;
        end
      end
      StStream: begin
        if (i_drain_req) begin
          w_state_next = StDrain;
        end else if (!i_enable) begin
          w_state_next = StIdle;
        end
      end
      StDrain: begin
        if (i_fifo_empty && !r_inflight && (r_occ == 2'd0)) begin
          w_state_next = StIdle;
          w_drain_exit = 1'b1;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Capture never sees occ == 2: the pop that produced it required occ + inflight < 2.
  always_comb begin
    w_buf0_next = r_buf0;
    w_buf1_next = r_buf1;
    w_occ_next  = r_occ;
    case ({w_cap, w_xfer})
      2'b10: begin
        if (r_occ == 2'd0) begin
          w_buf0_next = i_fifo_read_data;
        end else begin
          w_buf1_next = i_fifo_read_data;
        end
        w_occ_next = r_occ + 2'd1;
      end
      2'b01: begin
        w_buf0_next = r_buf1;
        w_occ_next  = r_occ - 2'd1;
      end
      2'b11: begin
        if (r_occ == 2'd1) begin
          w_buf0_next = i_fifo_read_data;
        end else begin
          w_buf0_next = r_buf1;
          w_buf1_next = i_fifo_read_data;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_occ        <= 2'd0;
      r_inflight   <= 1'b0;
      r_drain_done <= 1'b0;
      r_pop_count  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_occ        <= w_occ_next;
      r_inflight   <= w_read_en;
      r_drain_done <= w_drain_exit;
      if (w_xfer) begin
        r_pop_count <= r_pop_count + CntOne;
      end
    end
  end

  // Data storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    r_buf0 <= w_buf0_next;
    r_buf1 <= w_buf1_next;
  end

endmodule
